decode_fwd_stage: RTL and testbench
===================================

# decode_fwd_stage

Parametrised decode/operand-resolution stage for the RV32 pipeline, sitting between fetch and execute. It holds the fetched instruction in an ID register, resolves rs1/rs2 operands through an N-source forwarding network with register-file fallback, and registers the instruction and both operands into an ID/EX output register. It also detects load-use hazards internally, handles flush and external stall, and keeps a saturating hazard-stall counter.

## Interface
Parameters:
- XLEN, 32, datapath width
- NUM_FWD, 2, number of forwarding sources; index 0 has highest priority (nearest stage)
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0)
- CNT_W, 16, hazard counter width

Ports:
- clk  in  1  sole clock; one clock; reset is synchronous and active-low
- rst  in  1  active-low synchronous reset, sampled on rising clk
- ins_dec_in  in  32  instruction from fetch
- stall_in  in  1  downstream freeze request
- flush  in  1  branch/jump redirect; kills younger instructions
- rso1, rso2  in  XLEN  register-file read data for rs1/rs2
- rs1, rs2  out  5  register addresses decoded from the ID register, to the register file
- fwd_en  in  NUM_FWD  per-source write-enable
- fwd_rd  in  5*NUM_FWD  per-source destination register, packed, source i at [5i+4:5i]
- fwd_val  in  XLEN*NUM_FWD  per-source result, packed
- ins_ex_out  out  32  registered instruction to execute
- alu_in1, alu_in2  out  XLEN  registered resolved operands
- ex_valid  out  1  ins_ex_out is a real instruction
- stall_out  out  1  fetch must hold ins_dec_in this cycle
- hazard_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
- ID register: id_ins, id_valid. EX register: ins_ex_out, alu_in1, alu_in2, ex_valid.
- Operand usage: rs1 used unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111; rs2 used only by R-type 0110011, STORE 0100011 and BRANCH 1100011.
- Forwarding per operand: the lowest index i with fwd_en[i]=1, fwd_rd_i == rs and rs != 0 supplies fwd_val_i. Otherwise the operand is rso. x0 always resolves to rso and is never forwarded.
- Load-use hazard: ex_valid, ins_ex_out opcode 0000011, rd_ex != 0, id_valid and rd_ex equals a *used* rs of id_ins.
- Priority each cycle: reset, then flush, then stall_in, then hazard, then normal.
  - reset: id_ins=NOP, id_valid=0, EX register = NOP/0/0, ex_valid=0, hazard_cnt=0.
  - flush: id_ins=NOP, id_valid=0, EX register loads NOP with ex_valid=0. Fetch input is discarded.
  - stall_in: both registers hold, counter holds.
  - hazard: ID holds, EX register loads NOP with ex_valid=0, hazard_cnt+1 (saturates at all-ones).
  - normal: ID loads ins_dec_in with id_valid=1. EX register loads id_ins/id_valid and the resolved operands.
- stall_out = stall_in | hazard, combinational. It is forced to 0 during flush and while rst=0.

## Timing
- Latency: instruction on ins_dec_in at edge n appears on ins_ex_out after edge n+1, with no stall.
- Forwarding is sampled in the cycle the instruction leaves ID. Values forwarded in later cycles do not affect the latched operands.
- A load followed immediately by a dependent instruction costs exactly 1 bubble cycle. After the bubble, the load result arrives via the fwd source wired from MEM.
- Flush together with a hazard or stall_in: flush wins and the counter is not incremented.
- A reset asserted mid-stall clears everything in the same edge. First fetch is accepted on the first edge with rst=1.

## Structure
- Shared package rv32_pkg: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_LUI, OP_AUIPC, OP_JAL), the NOP constant and field-slice helpers.
- One sub-module, fwd_mux: a parametrised priority operand selector (NUM_FWD, XLEN), instantiated twice.

## Test plan
- Reset with rst=0 for 2 cycles -> ins_ex_out=0x00000013, ex_valid=0, alu_in1=alu_in2=0, hazard_cnt=0, stall_out=0.
- Priority forwarding: add x5,x1,x2 with fwd0 (x1,0xAAAA) and fwd1 (x1,0xBBBB) both enabled and rso1=0x1111 -> alu_in1=0xAAAA. With fwd_en=00 -> 0x1111.
- x0 guard: add x3,x0,x0 with fwd0 (rd=0,0xDEAD) enabled -> alu_in1=alu_in2=rso values.
- Load-use: lw x6,0(x1) then add x7,x6,x2 -> stall_out=1 for exactly one cycle, one NOP bubble with ex_valid=0, hazard_cnt=1. Then add issues with the forwarded value. Repeating with lui x6 as the consumer gives no stall.
- Flush during hazard: assert flush in the stall cycle -> both registers become NOP/invalid, hazard_cnt unchanged, stall_out=0.
- stall_in held for 3 cycles -> ins_ex_out, alu_in1/2 and hazard_cnt remain constant, stall_out=1 throughout.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions.
// Holds the major opcodes the decode stage inspects, the canonical bubble
// instruction, the per-cycle action of the decode stage and helpers that
// slice instruction fields and tell which source registers an opcode reads.
package rv32_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // What the decode stage does with its two registers on the next edge.
    typedef enum logic [1:0] {
        ActAdvance,  // ID takes fetch, EX takes ID
        ActHold,     // both registers keep their contents
        ActBubble,   // ID keeps its instruction, EX takes a NOP
        ActFlush     // both registers become NOP/invalid
    } stage_act_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] ins);
        return ins[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ins);
        return ins[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] ins);
        return ins[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] ins);
        return ins[24:20];
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority operand selector.
// Picks the result of the lowest-index enabled forwarding source whose
// destination matches the requested register; otherwise (or for x0) passes
// the register-file read data through.
//   rs       in  requested source register
//   rso      in  register-file read data for rs
//   fwd_en   in  per-source valid
//   fwd_rd   in  per-source destination, source i at [5i+4:5i]
//   fwd_val  in  per-source result, source i at [XLEN*i +: XLEN]
//   operand  out resolved operand
module fwd_mux #(
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic [4:0]              rs,
    input  logic [XLEN-1:0]         rso,
    input  logic [NUM_FWD-1:0]      fwd_en,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_val,
    output logic [XLEN-1:0]         operand
);

    always_comb begin
        operand = rso;
        // Walk from the farthest source to the nearest so index 0 wins last.
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_en[i] && (rs != 5'd0) && (fwd_rd[5*i +: 5] == rs)) begin
                operand = fwd_val[XLEN*i +: XLEN];
            end
        end
    end

endmodule

// File: rtl/decode_fwd_stage.sv
// RV32 decode / operand-resolution stage.
// Holds the fetched instruction in an ID register, resolves rs1/rs2 through
// the forwarding network (falling back to register-file data), and registers
// instruction plus operands into the ID/EX register. Inserts one bubble on a
// load-use dependency and counts those stall cycles (saturating).
//   clk, rst              clock, synchronous active-low reset
//   ins_dec_in            instruction from fetch
//   stall_in, flush       downstream freeze, branch/jump redirect
//   rso1, rso2 / rs1, rs2 register-file read data / read addresses
//   fwd_en/fwd_rd/fwd_val forwarding sources, index 0 highest priority
//   ins_ex_out, alu_in1, alu_in2, ex_valid  ID/EX register
//   stall_out             fetch must hold its instruction
//   hazard_cnt            saturating load-use stall count
module decode_fwd_stage
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter logic [31:0] NOP     = NOP_INSN,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             ins_dec_in,
    input  logic                    stall_in,
    input  logic                    flush,
    input  logic [XLEN-1:0]         rso1,
    input  logic [XLEN-1:0]         rso2,
    output logic [4:0]              rs1,
    output logic [4:0]              rs2,
    input  logic [NUM_FWD-1:0]      fwd_en,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_val,
    output logic [31:0]             ins_ex_out,
    output logic [XLEN-1:0]         alu_in1,
    output logic [XLEN-1:0]         alu_in2,
    output logic                    ex_valid,
    output logic                    stall_out,
    output logic [CNT_W-1:0]        hazard_cnt
);

    logic [31:0]      id_ins_q, id_ins_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      ex_ins_q, ex_ins_d;
    logic [XLEN-1:0]  ex_op1_q, ex_op1_d;
    logic [XLEN-1:0]  ex_op2_q, ex_op2_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  op1_res, op2_res;
    logic [4:0]       rd_ex;
    logic             load_use;
    stage_act_e       act;

    assign rs1   = rs1_of(id_ins_q);
    assign rs2   = rs2_of(id_ins_q);
    assign rd_ex = rd_of(ex_ins_q);

    // The load in EX has no result yet, so a consumer in ID must wait a cycle
    // and pick the value up from the MEM-side forwarding source.
    assign load_use = ex_valid_q && (opcode_of(ex_ins_q) == OP_LOAD) && (rd_ex != 5'd0)
                      && id_valid_q
                      && ((uses_rs1(id_ins_q) && (rd_ex == rs1))
                          || (uses_rs2(id_ins_q) && (rd_ex == rs2)));

    assign stall_out = rst & ~flush & (stall_in | load_use);

    fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .XLEN    (XLEN)
    ) u_fwd_rs1 (
        .rs      (rs1),
        .rso     (rso1),
        .fwd_en  (fwd_en),
        .fwd_rd  (fwd_rd),
        .fwd_val (fwd_val),
        .operand (op1_res)
    );

    fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .XLEN    (XLEN)
    ) u_fwd_rs2 (
        .rs      (rs2),
        .rso     (rso2),
        .fwd_en  (fwd_en),
        .fwd_rd  (fwd_rd),
        .fwd_val (fwd_val),
        .operand (op2_res)
    );

    always_comb begin
        if (flush) begin
            act = ActFlush;
        end else if (stall_in) begin
            act = ActHold;
        end else if (load_use) begin
            act = ActBubble;
        end else begin
            act = ActAdvance;
        end
    end

    always_comb begin
        id_ins_d   = id_ins_q;
        id_valid_d = id_valid_q;
        ex_ins_d   = ex_ins_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_valid_d = ex_valid_q;
        cnt_d      = cnt_q;
        unique case (act)
            ActFlush: begin
                id_ins_d   = NOP;
                id_valid_d = 1'b0;
                ex_ins_d   = NOP;
                ex_op1_d   = '0;
                ex_op2_d   = '0;
                ex_valid_d = 1'b0;
            end
            ActHold: begin
            end
            ActBubble: begin
                ex_ins_d   = NOP;
                ex_op1_d   = '0;
                ex_op2_d   = '0;
                ex_valid_d = 1'b0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ActAdvance: begin
                id_ins_d   = ins_dec_in;
                id_valid_d = 1'b1;
                ex_ins_d   = id_ins_q;
                ex_op1_d   = op1_res;
                ex_op2_d   = op2_res;
                ex_valid_d = id_valid_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ins_q   <= NOP;
            id_valid_q <= 1'b0;
            ex_ins_q   <= NOP;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            id_ins_q   <= id_ins_d;
            id_valid_q <= id_valid_d;
            ex_ins_q   <= ex_ins_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_valid_q <= ex_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ins_ex_out = ex_ins_q;
    assign alu_in1    = ex_op1_q;
    assign alu_in2    = ex_op2_q;
    assign ex_valid   = ex_valid_q;
    assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Bench for decode_fwd_stage: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the stage.
module tb_decode_fwd_stage;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [31:0]             ins_dec_in = NOP;
    logic                    stall_in = 1'b0;
    logic                    flush = 1'b0;
    logic [XLEN-1:0]         rso1 = '0;
    logic [XLEN-1:0]         rso2 = '0;
    logic [4:0]              rs1, rs2;
    logic [NUM_FWD-1:0]      fwd_en = '0;
    logic [5*NUM_FWD-1:0]    fwd_rd = '0;
    logic [XLEN*NUM_FWD-1:0] fwd_val = '0;
    logic [31:0]             ins_ex_out;
    logic [XLEN-1:0]         alu_in1, alu_in2;
    logic                    ex_valid;
    logic                    stall_out;
    logic [CNT_W-1:0]        hazard_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: contents of the ID and EX slots plus the stall count.
    logic [31:0] m_id_ins, m_ex_ins, m_a1, m_a2;
    bit          m_id_v, m_ex_v, m_ops_known;
    int          m_cnt;

    decode_fwd_stage #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .NOP     (NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_dec_in (ins_dec_in),
        .stall_in   (stall_in),
        .flush      (flush),
        .rso1       (rso1),
        .rso2       (rso2),
        .rs1        (rs1),
        .rs2        (rs2),
        .fwd_en     (fwd_en),
        .fwd_rd     (fwd_rd),
        .fwd_val    (fwd_val),
        .ins_ex_out (ins_ex_out),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .ex_valid   (ex_valid),
        .stall_out  (stall_out),
        .hazard_cnt (hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int ra, input int rb);
        return {7'd0, 5'(rb), 5'(ra), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_lw(input int rd, input int ra);
        return {12'd0, 5'(ra), 3'b010, 5'(rd), 7'h03};
    endfunction

    function automatic logic [31:0] enc_lui(input int rd);
        return {20'h12345, 5'(rd), 7'h37};
    endfunction

    function automatic bit reads_a(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
    endfunction

    function automatic bit reads_b(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return op == 7'h33 || op == 7'h23 || op == 7'h63;
    endfunction

    // Nearest matching enabled source, never for x0.
    function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (fwd_en[i] && fwd_rd[5*i +: 5] == r) return fwd_val[32*i +: 32];
        end
        return rf;
    endfunction

    function automatic bit model_hazard();
        logic [4:0] d;
        d = m_ex_ins[11:7];
        if (!(m_ex_v && m_id_v && m_ex_ins[6:0] == 7'h03 && d != 5'd0)) return 1'b0;
        return (reads_a(m_id_ins) && d == m_id_ins[19:15])
            || (reads_b(m_id_ins) && d == m_id_ins[24:20]);
    endfunction

    task automatic model_reset();
        m_id_ins = NOP; m_id_v = 0;
        m_ex_ins = NOP; m_ex_v = 0;
        m_a1 = '0; m_a2 = '0; m_ops_known = 1;
        m_cnt = 0;
    endtask

    // Entered at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step();
        bit hz;
        @(negedge clk);
        hz = model_hazard();
        check("stall_out", {31'd0, stall_out}, {31'd0, rst && !flush && (stall_in || hz)});
        check("rs1", {27'd0, rs1}, {27'd0, m_id_ins[19:15]});
        check("rs2", {27'd0, rs2}, {27'd0, m_id_ins[24:20]});
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (flush) begin
            m_id_ins = NOP; m_id_v = 0;
            m_ex_ins = NOP; m_ex_v = 0; m_ops_known = 0;
        end else if (stall_in) begin
            // everything keeps its value
        end else if (hz) begin
            m_ex_ins = NOP; m_ex_v = 0; m_ops_known = 0;
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else begin
            m_a1 = resolve(m_id_ins[19:15], rso1);
            m_a2 = resolve(m_id_ins[24:20], rso2);
            m_ops_known = 1;
            m_ex_ins = m_id_ins; m_ex_v = m_id_v;
            m_id_ins = ins_dec_in; m_id_v = 1;
        end
        #1;
        check("ins_ex_out", ins_ex_out, m_ex_ins);
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_v});
        check("hazard_cnt", {29'd0, hazard_cnt}, m_cnt);
        if (m_ops_known) begin
            check("alu_in1", alu_in1, m_a1);
            check("alu_in2", alu_in2, m_a2);
        end
    endtask

    task automatic load_use_pair();
        fwd_en = '0;
        ins_dec_in = enc_lw(6, 1); step();
        ins_dec_in = enc_r(7, 6, 2); step();
    endtask

    logic [6:0] ops [8];

    initial begin
        ops = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h13};

        // Reset for two cycles.
        @(posedge clk); #1;
        model_reset();
        step();
        check("rst_ins", ins_ex_out, NOP);
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_alu1", alu_in1, 32'd0);
        check("rst_alu2", alu_in2, 32'd0);
        check("rst_cnt", {29'd0, hazard_cnt}, 32'd0);
        check("rst_stall", {31'd0, stall_out}, 32'd0);
        rst = 1'b1;

        // Priority forwarding: source 0 beats source 1.
        ins_dec_in = enc_r(5, 1, 2); step();
        ins_dec_in = NOP;
        fwd_en = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_val = {32'hBBBB, 32'hAAAA};
        rso1 = 32'h1111; rso2 = 32'h2222;
        step();
        check("fwd_prio_ins", ins_ex_out, enc_r(5, 1, 2));
        check("fwd_prio", alu_in1, 32'h0000_AAAA);
        check("fwd_prio_rs2", alu_in2, 32'h0000_2222);
        ins_dec_in = enc_r(5, 1, 2); step();
        ins_dec_in = NOP; fwd_en = 2'b00; step();
        check("fwd_none", alu_in1, 32'h0000_1111);

        // x0 is never forwarded.
        ins_dec_in = enc_r(3, 0, 0); step();
        ins_dec_in = NOP;
        fwd_en = 2'b01; fwd_rd = '0; fwd_val = {32'h0, 32'hDEAD};
        rso1 = 32'h3333; rso2 = 32'h4444;
        step();
        check("x0_alu1", alu_in1, 32'h3333);
        check("x0_alu2", alu_in2, 32'h4444);

        // Load-use: one bubble, then the consumer takes the MEM-forwarded value.
        load_use_pair();
        check("lu_stall", {31'd0, stall_out}, 32'd1);
        ins_dec_in = NOP; step();
        check("lu_bubble_ins", ins_ex_out, NOP);
        check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_cnt", {29'd0, hazard_cnt}, 32'd1);
        check("lu_stall_once", {31'd0, stall_out}, 32'd0);
        fwd_en = 2'b01; fwd_rd = {5'd0, 5'd6}; fwd_val = {32'h0, 32'h5555};
        rso1 = 32'h9999;
        step();
        check("lu_issue_ins", ins_ex_out, enc_r(7, 6, 2));
        check("lu_issue_fwd", alu_in1, 32'h5555);
        check("lu_issue_valid", {31'd0, ex_valid}, 32'd1);

        // LUI does not read rs1, so no stall.
        fwd_en = '0;
        ins_dec_in = enc_lw(6, 1); step();
        ins_dec_in = enc_lui(6); step();
        check("lui_nostall", {31'd0, stall_out}, 32'd0);
        ins_dec_in = NOP; step();
        check("lui_issue", ins_ex_out, enc_lui(6));

        // Flush in the hazard cycle wins over the bubble.
        load_use_pair();
        ins_dec_in = enc_r(8, 1, 1);
        flush = 1'b1; #1;
        check("flush_stall", {31'd0, stall_out}, 32'd0);
        step();
        flush = 1'b0;
        check("flush_ins", ins_ex_out, NOP);
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_cnt", {29'd0, hazard_cnt}, 32'd1);
        check("flush_id", {27'd0, rs1}, 32'd0);

        // stall_in holds everything, later forwarding is ignored.
        ins_dec_in = enc_r(9, 1, 2); step();
        ins_dec_in = NOP; fwd_en = '0; rso1 = 32'h7777; rso2 = 32'h8888; step();
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fwd_en = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_val = {$urandom, $urandom};
            rso1 = $urandom; rso2 = $urandom;
            step();
            check("hold_ins", ins_ex_out, enc_r(9, 1, 2));
            check("hold_alu1", alu_in1, 32'h7777);
            check("hold_alu2", alu_in2, 32'h8888);
            check("hold_cnt", {29'd0, hazard_cnt}, 32'd1);
            check("hold_stall", {31'd0, stall_out}, 32'd1);
        end
        stall_in = 1'b0;

        // Drive the counter into saturation.
        for (int k = 0; k < 8; k++) begin
            load_use_pair();
            ins_dec_in = NOP; step();
            step();
        end
        check("cnt_sat", {29'd0, hazard_cnt}, CNT_MAX);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 7)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            ins_dec_in = ins;
            rst      = ($urandom_range(0, 99) >= 2);
            flush    = ($urandom_range(0, 99) < 5);
            stall_in = ($urandom_range(0, 99) < 10);
            fwd_en   = NUM_FWD'($urandom);
            fwd_rd   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_val  = {$urandom, $urandom};
            rso1     = $urandom;
            rso2     = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
